// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encoding, register-address width default, NOP encoding.
// Imported by the hazard controller and its load-use comparator.
package pipeline_pkg;
    localparam int          REG_AW_DEF = 5;
    localparam logic [31:0] NOP_INSN   = 32'h00000013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard bus: IF/ID and ID/EX fields in, pipeline enable/flush controls out.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] if_id_rs1;
    logic [REG_AW-1:0] if_id_rs2;
    logic              if_id_use_rs1;
    logic              if_id_use_rs2;
    logic              id_ex_memread;
    logic [REG_AW-1:0] id_ex_rd;
    logic              branch_taken;
    logic              mem_busy;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              pipe_freeze;
    logic [1:0]        state_out;

    modport master (
        output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
               id_ex_memread, id_ex_rd, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, state_out
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
               id_ex_memread, id_ex_rd, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, state_out
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use comparator; x0 never hazards. Kept standalone so the
// forwarding unit can reuse it.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              memread,
    input  logic [REG_AW-1:0] rd,
    output logic              lu
);
    logic hit1, hit2;

    assign hit1 = use_rs1 && (rd == rs1);
    assign hit2 = use_rs2 && (rd == rs2);
    assign lu   = memread && (rd != '0) && (hit1 || hit2);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock/flush controller: mem_busy freeze > branch flush > load-use stall.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic              clock,
    input  logic              reset,
    hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);
    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

    hz_state_e  state;
    logic [3:0] cnt;
    logic       pending;
    logic       lu;
    logic       do_freeze, do_redirect, do_stall;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .rs1     (hz.if_id_rs1),
        .rs2     (hz.if_id_rs2),
        .use_rs1 (hz.if_id_use_rs1),
        .use_rs2 (hz.if_id_use_rs2),
        .memread (hz.id_ex_memread),
        .rd      (hz.id_ex_rd),
        .lu      (lu)
    );

    // Freeze wins in every state; reset forces the free-running defaults.
    always_comb begin
        do_freeze   = !reset && hz.mem_busy;
        do_redirect = 1'b0;
        do_stall    = 1'b0;
        if (!reset && !hz.mem_busy) begin
            case (state)
                RUN: begin
                    do_redirect = hz.branch_taken;
                    do_stall    = !hz.branch_taken && lu;
                end
                FLUSH:    do_redirect = 1'b1;
                MEM_WAIT: begin
                    do_redirect = pending || hz.branch_taken;
                    do_stall    = !(pending || hz.branch_taken) && lu;
                end
                default: ;
            endcase
        end
    end

    assign hz.pc_write     = !(do_freeze || do_stall);
    assign hz.if_id_write  = !(do_freeze || do_stall);
    assign hz.if_id_flush  = do_redirect;
    assign hz.id_ex_bubble = do_redirect || do_stall;
    assign hz.pipe_freeze  = do_freeze;
    assign hz.state_out    = reset ? 2'd0 : state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= 4'd0;
            pending <= 1'b0;
        end else if (hz.mem_busy) begin
            // Branches resolved during a freeze are replayed once memory is ready.
            pending <= pending || hz.branch_taken;
            case (state)
                RUN:             state <= MEM_WAIT;
                FLUSH, MEM_WAIT: ;
                default:         state <= RUN;
            endcase
        end else begin
            pending <= 1'b0;
            case (state)
                RUN, MEM_WAIT: begin
                    if (do_redirect && FLUSH_CYCLES > 1) begin
                        state <= FLUSH;
                        cnt   <= RELOAD;
                    end else begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    if (hz.branch_taken || pending) begin
                        cnt <= RELOAD;
                    end else if (cnt <= 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!hz.pc_write && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (hz.if_id_flush && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=3.
// Observed vector = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, state_out[1:0]}.
module tb_hazard_ctrl;
    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(3)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (bus.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    logic [6:0] obs;
    assign obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                  bus.pipe_freeze, bus.state_out};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic mb);
        bus.id_ex_memread = mr;
        bus.id_ex_rd      = rd;
        bus.if_id_rs1     = rs1;
        bus.if_id_rs2     = rs2;
        bus.if_id_use_rs1 = u1;
        bus.if_id_use_rs2 = u2;
        bus.branch_taken  = br;
        bus.mem_busy      = mb;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, 7'b1100000); end
        tick();
        drive(1, 5, 5, 0, 1, 0, 1, 1);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL reset_masks_inputs: got %b want %b", obs, 7'b1100000); end
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL run_idle: got %b want %b", obs, 7'b1100000); end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL cnt_reset: got %0d/%0d want 0/0", stall_count, flush_count);
        end
`endif
        tick();
    endtask

    task automatic test_load_use();
        drive(1, 5, 5, 0, 1, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b0001000) begin n_fail++; $display("FAIL lu_rs1_stall: got %b want %b", obs, 7'b0001000); end
        tick();
        drive(0, 5, 5, 0, 1, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL lu_release: got %b want %b", obs, 7'b1100000); end
        tick();
        drive(1, 7, 3, 7, 1, 1, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b0001000) begin n_fail++; $display("FAIL lu_rs2_stall: got %b want %b", obs, 7'b0001000); end
        tick();
        drive(1, 9, 9, 9, 0, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL lu_unused_src: got %b want %b", obs, 7'b1100000); end
        tick();
    endtask

    task automatic test_x0();
        drive(1, 0, 4, 0, 0, 1, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL x0_filter: got %b want %b", obs, 7'b1100000); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_branch_flush();
        logic [6:0] exp_seq [4];
        exp_seq[0] = 7'b1111000;
        exp_seq[1] = 7'b1111001;
        exp_seq[2] = 7'b1111001;
        exp_seq[3] = 7'b1100000;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, (i == 0), 0);
            @(negedge clock);
            n_checks++;
            if (obs !== exp_seq[i]) begin n_fail++; $display("FAIL branch_flush[%0d]: got %b want %b", i, obs, exp_seq[i]); end
            tick();
        end
    endtask

    task automatic test_mem_wait_branch();
        logic [6:0] exp_seq [8];
        exp_seq[0] = 7'b0000100;
        exp_seq[1] = 7'b0000110;
        exp_seq[2] = 7'b0000110;
        exp_seq[3] = 7'b0000110;
        exp_seq[4] = 7'b1111010;
        exp_seq[5] = 7'b1111001;
        exp_seq[6] = 7'b1111001;
        exp_seq[7] = 7'b1100000;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, (i == 1), (i < 4));
            @(negedge clock);
            n_checks++;
            if (obs !== exp_seq[i]) begin n_fail++; $display("FAIL memwait_branch[%0d]: got %b want %b", i, obs, exp_seq[i]); end
            tick();
        end
    endtask

    task automatic test_priority();
        drive(1, 6, 6, 0, 1, 0, 1, 1);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b0000100) begin n_fail++; $display("FAIL prio_freeze_only: got %b want %b", obs, 7'b0000100); end
        tick();
        drive(1, 6, 6, 0, 1, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1111010) begin n_fail++; $display("FAIL prio_branch_over_lu: got %b want %b", obs, 7'b1111010); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL prio_back_to_run: got %b want %b", obs, 7'b1100000); end
        tick();
    endtask

    task automatic test_mem_wait_lu();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 8, 8, 0, 1, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b0001010) begin n_fail++; $display("FAIL memwait_lu_stall: got %b want %b", obs, 7'b0001010); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL memwait_lu_release: got %b want %b", obs, 7'b1100000); end
        tick();
    endtask

    task automatic test_flush_busy_reload();
        // branch, freeze inside FLUSH (counter holds), then a second branch reloads
        logic [6:0] exp_seq [7];
        logic [6:0] br_pat, mb_pat;
        exp_seq[0] = 7'b1111000;
        exp_seq[1] = 7'b0000101;
        exp_seq[2] = 7'b1111001;
        exp_seq[3] = 7'b1111001;
        exp_seq[4] = 7'b1111001;
        exp_seq[5] = 7'b1111001;
        exp_seq[6] = 7'b1100000;
        br_pat = 7'b0001001;
        mb_pat = 7'b0000010;
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 0, 0, br_pat[i], mb_pat[i]);
            @(negedge clock);
            n_checks++;
            if (obs !== exp_seq[i]) begin n_fail++; $display("FAIL flush_busy_reload[%0d]: got %b want %b", i, obs, exp_seq[i]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL reset_in_flush: got %b want %b", obs, 7'b1100000); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL after_reset_flush: got %b want %b", obs, 7'b1100000); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs !== 7'b1100000) begin n_fail++; $display("FAIL pending_cleared: got %b want %b", obs, 7'b1100000); end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL cnt_after_reset: got %0d/%0d want 0/0", stall_count, flush_count);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_branch_flush();
        test_mem_wait_branch();
        test_priority();
        test_mem_wait_lu();
        test_flush_busy_reload();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
